// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel gradient magnitude over a 2*WIDTH+3 byte line-buffer window.
// Define SOBEL_THRESHOLD_EN to binarize the output against THRESHOLD.
module sobel_edge_filter #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int THRESHOLD = 48
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);

  localparam int SR_LEN = 2*WIDTH+3;
  localparam int NPIX   = WIDTH*HEIGHT;
  localparam int PW     = $clog2(NPIX+1);
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);

  typedef enum logic [1:0] {
    PROLOGUE,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sr_q [SR_LEN];
  logic [7:0]    sr_d [SR_LEN];
  logic [PW-1:0] pop_q, pop_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    mag_q, mag_d;
  logic          last_q, last_d;

  logic [10:0] pos_x, neg_x, pos_y, neg_y;
  logic [10:0] gx, gy, ax, ay;
  logic [9:0]  m;
  logic [7:0]  mag_val;
  logic [7:0]  shift_in;
  logic        border, flush, shift, last_pix;

  // Gradients wrap mod 2^11; true range is +/-1020 so bit 10 is the sign.
  always_comb begin
    pos_x = {3'b0, sr_q[2]} + {2'b0, sr_q[WIDTH+2], 1'b0}
          + {3'b0, sr_q[2*WIDTH+2]};
    neg_x = {3'b0, sr_q[0]} + {2'b0, sr_q[WIDTH], 1'b0}
          + {3'b0, sr_q[2*WIDTH]};
    pos_y = {3'b0, sr_q[2*WIDTH]} + {2'b0, sr_q[2*WIDTH+1], 1'b0}
          + {3'b0, sr_q[2*WIDTH+2]};
    neg_y = {3'b0, sr_q[0]} + {2'b0, sr_q[1], 1'b0}
          + {3'b0, sr_q[2]};
    gx = pos_x - neg_x;
    gy = pos_y - neg_y;
    ax = gx[10] ? (~gx + 11'd1) : gx;
    ay = gy[10] ? (~gy + 11'd1) : gy;
    m  = 10'((ax + ay) >> 1);
`ifdef SOBEL_THRESHOLD_EN
    mag_val = ({1'b0, m} >= 11'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
    mag_val = (m > 10'd255) ? 8'hFF : m[7:0];
`endif
    border = (row_q == '0) || (row_q == RW'(HEIGHT-1))
          || (col_q == '0) || (col_q == CW'(WIDTH-1));
    last_pix = (row_q == RW'(HEIGHT-1)) && (col_q == CW'(WIDTH-1));
  end

  always_comb begin
    state_d   = state_q;
    pop_d     = pop_q;
    col_d     = col_q;
    row_d     = row_q;
    mag_d     = mag_q;
    last_d    = last_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    shift     = 1'b0;
    shift_in  = in_dout;
    flush     = (pop_q == PW'(NPIX));
    unique case (state_q)
      PROLOGUE: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          shift    = 1'b1;
          pop_d    = pop_q + PW'(1);
          if (pop_q == PW'(WIDTH+1)) begin
            state_d = COMPUTE;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      COMPUTE: begin
        if (flush || !in_empty) begin
          shift = 1'b1;
          if (flush) begin
            shift_in = 8'h00;
          end else begin
            in_rd_en = 1'b1;
            pop_d    = pop_q + PW'(1);
          end
          mag_d  = border ? 8'h00 : mag_val;
          last_d = last_pix;
          if (col_q == CW'(WIDTH-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(HEIGHT-1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          if (last_q) begin
            state_d = PROLOGUE;
            pop_d   = '0;
            row_d   = '0;
            col_d   = '0;
            last_d  = 1'b0;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = PROLOGUE;
    endcase
    for (int i = 0; i < SR_LEN; i++) sr_d[i] = sr_q[i];
    if (shift) begin
      for (int i = 0; i < SR_LEN-1; i++) sr_d[i] = sr_q[i+1];
      sr_d[SR_LEN-1] = shift_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PROLOGUE;
      pop_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      mag_q   <= 8'h00;
      last_q  <= 1'b0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mag_q   <= mag_d;
      last_q  <= last_d;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= sr_d[i];
    end
  end

  assign out_din = mag_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Directed bench for sobel_edge_filter on an 8x6 frame.
// Honors SOBEL_THRESHOLD_EN in its reference values.
module tb_sobel_edge_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W*H;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_empty = 1'b1;
  logic       out_full = 1'b0;
  logic [7:0] in_dout = 8'h00;
  logic       in_rd_en;
  logic       out_wr_en;
  logic [7:0] out_din;

  always #5 clock = ~clock;

  sobel_edge_filter #(
    .WIDTH(W),
    .HEIGHT(H),
    .THRESHOLD(48)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (in_rd_en),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  typedef struct {
    int kind;
    int r;
    int c;
    int exp;
  } vec_t;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] src[$];
  logic [7:0] got[$];
  int         pops;
  int         wr_full;
  int         rd_empty;
  int         res[3][N];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // 0 = flat 100, 1 = vertical step 0/200, 2 = ramp 10*col
  function automatic int pix(input int k, input int r, input int c);
    if (k == 0) return 100;
    if (k == 1) return (c < 4) ? 0 : 200;
    return 10*c;
  endfunction

  function automatic int gold(input int k, input int r, input int c);
    int gx, gy, m;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = pix(k,r-1,c+1) + 2*pix(k,r,c+1) + pix(k,r+1,c+1)
       - pix(k,r-1,c-1) - 2*pix(k,r,c-1) - pix(k,r+1,c-1);
    gy = pix(k,r+1,c-1) + 2*pix(k,r+1,c) + pix(k,r+1,c+1)
       - pix(k,r-1,c-1) - 2*pix(k,r-1,c) - pix(k,r-1,c+1);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
`ifdef SOBEL_THRESHOLD_EN
    return (m >= 48) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  task automatic load(input int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        src.push_back(8'(pix(k, r, c)));
  endtask

  task automatic run_stream(input int n_out, input bit stall,
                            input bit rnd);
    int  full_left = 0;
    int  cyc = 0;
    bit  stalled = 0;
    got.delete();
    pops = 0;
    wr_full = 0;
    rd_empty = 0;
    while (got.size() < n_out && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (stall && !stalled && got.size() == 20) begin
        full_left = 10;
        stalled = 1;
      end
      out_full = (full_left > 0);
      if (full_left > 0) full_left--;
      in_empty = (src.size() == 0) || (rnd && $urandom_range(0, 2) == 0);
      in_dout = (src.size() != 0) ? src[0] : 8'h00;
      #1;
      if (in_rd_en) begin
        if (in_empty) rd_empty++;
        else void'(src.pop_front());
        pops++;
      end
      if (out_wr_en) begin
        if (out_full) wr_full++;
        got.push_back(out_din);
      end
    end
    out_full = 1'b0;
  endtask

  task automatic cmp_frame(input string name, input int off, input int k);
    for (int i = 0; i < N; i++)
      if (off + i < got.size())
        chk($sformatf("%s_px%0d", name, i), int'(got[off+i]),
            gold(k, i / W, i % W));
  endtask

  task automatic check_prologue(input string name);
    @(negedge clock);
    in_empty = 1'b0;
    #1;
    chk({name, "_prologue_rd"}, int'(in_rd_en), 1);
    chk({name, "_prologue_wr"}, int'(out_wr_en), 0);
    in_empty = 1'b1;
  endtask

  initial begin
    vec_t tbl[14];
    tbl[0]  = '{0, 2, 3, 0};
    tbl[1]  = '{0, 4, 6, 0};
    tbl[2]  = '{1, 1, 3, 255};
    tbl[3]  = '{1, 4, 4, 255};
    tbl[4]  = '{1, 2, 2, 0};
    tbl[5]  = '{1, 3, 5, 0};
    tbl[6]  = '{1, 0, 3, 0};
    tbl[7]  = '{1, 5, 4, 0};
    tbl[8]  = '{2, 2, 0, 0};
    tbl[9]  = '{2, 2, 7, 0};
    tbl[10] = '{2, 0, 4, 0};
`ifdef SOBEL_THRESHOLD_EN
    tbl[11] = '{2, 1, 1, 0};
    tbl[12] = '{2, 4, 6, 0};
    tbl[13] = '{2, 3, 3, 0};
`else
    tbl[11] = '{2, 1, 1, 40};
    tbl[12] = '{2, 4, 6, 40};
    tbl[13] = '{2, 3, 3, 40};
`endif

    repeat (3) @(negedge clock);
    #1;
    chk("rst_rd_en", int'(in_rd_en), 0);
    chk("rst_wr_en", int'(out_wr_en), 0);
    chk("rst_out_din", int'(out_din), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 3; k++) begin
      load(k);
      run_stream(N, 0, 0);
      chk($sformatf("k%0d_outputs", k), got.size(), N);
      chk($sformatf("k%0d_pops", k), pops, N);
      chk($sformatf("k%0d_rd_empty", k), rd_empty, 0);
      for (int i = 0; i < N; i++)
        res[k][i] = (i < got.size()) ? int'(got[i]) : -1;
      cmp_frame($sformatf("k%0d", k), 0, k);
      check_prologue($sformatf("k%0d", k));
    end

    foreach (tbl[i])
      chk($sformatf("tbl%0d_k%0d_r%0d_c%0d", i, tbl[i].kind, tbl[i].r,
                    tbl[i].c),
          res[tbl[i].kind][tbl[i].r*W + tbl[i].c], tbl[i].exp);

    load(1);
    run_stream(N, 1, 1);
    chk("stall_outputs", got.size(), N);
    chk("stall_pops", pops, N);
    chk("stall_wr_while_full", wr_full, 0);
    chk("stall_rd_while_empty", rd_empty, 0);
    for (int i = 0; i < N; i++)
      if (i < got.size())
        chk($sformatf("stall_px%0d", i), int'(got[i]), res[1][i]);
    check_prologue("stall");

    load(1);
    load(0);
    run_stream(2*N, 0, 1);
    chk("b2b_outputs", got.size(), 2*N);
    chk("b2b_pops", pops, 2*N);
    cmp_frame("b2b_f0", 0, 1);
    cmp_frame("b2b_f1", N, 0);

    load(1);
    run_stream(30, 0, 0);
    reset = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("midrst_wr_%0d", i), int'(out_wr_en), 0);
      chk($sformatf("midrst_din_%0d", i), int'(out_din), 0);
      chk($sformatf("midrst_rd_%0d", i), int'(in_rd_en), 0);
      @(negedge clock);
    end
    reset = 1'b1;
    src.delete();
    load(1);
    run_stream(N, 0, 0);
    chk("post_rst_outputs", got.size(), N);
    chk("post_rst_pops", pops, N);
    cmp_frame("post_rst", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
